// File: rtl/regfile_access_sequencer_if.sv
// Request, operand-return and register-file port bundle around the access sequencer.
// The master side is the surrounding pipeline plus the register file; the sequencer is the slave.
interface regfile_access_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              fetch_valid;
    logic              fetch_ready;
    logic [ADDR_W-1:0] fetch_rs1;
    logic [ADDR_W-1:0] fetch_rs2;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rf_read_addr;
    logic [ADDR_W-1:0] rf_write_addr;
    logic              rf_r_or_w;
    logic [DATA_W-1:0] rf_write_val;
    logic [DATA_W-1:0] rf_read_value;
    logic              busy;

    modport master (
        output fetch_valid, fetch_rs1, fetch_rs2, op_ready, wb_valid, wb_addr, wb_data,
               rf_read_value,
        input  fetch_ready, op_valid, op_a, op_b, wb_ready, rf_read_addr, rf_write_addr,
               rf_r_or_w, rf_write_val, busy
    );

    modport slave (
        input  fetch_valid, fetch_rs1, fetch_rs2, op_ready, wb_valid, wb_addr, wb_data,
               rf_read_value,
        output fetch_ready, op_valid, op_a, op_b, wb_ready, rf_read_addr, rf_write_addr,
               rf_r_or_w, rf_write_val, busy
    );
endinterface

// File: rtl/regfile_access_sequencer.sv
// Serialises writebacks and two-operand fetches onto a single-port register file,
// writeback first, returning both operands through a valid/ready handshake.
module regfile_access_sequencer #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter bit ZERO_HARDWIRE = 1'b1
) (
    input logic                     clk,
    input logic                     reset,
    regfile_access_sequencer_if.slave bus
);

    typedef enum logic [2:0] {IDLE, WR, RD1, RD2, CAP, RESP} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic              wb_drop;

    // A writeback to x0 is acknowledged but never reaches the register file.
    assign wb_drop = ZERO_HARDWIRE && (bus.wb_addr == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_next        = state;
        bus.wb_ready      = 1'b0;
        bus.fetch_ready   = 1'b0;
        bus.op_valid      = 1'b0;
        bus.busy          = 1'b1;
        bus.rf_r_or_w     = 1'b1;
        bus.rf_read_addr  = '0;
        bus.rf_write_addr = '0;
        bus.rf_write_val  = '0;
        case (state)
            IDLE: begin
                bus.busy        = 1'b0;
                bus.wb_ready    = 1'b1;
                bus.fetch_ready = !bus.wb_valid;
                if (bus.wb_valid) begin
                    if (!wb_drop) state_next = WR;
                end else if (bus.fetch_valid) begin
                    state_next = RD1;
                end
            end
            WR: begin
                bus.rf_r_or_w     = 1'b0;
                bus.rf_write_addr = wb_addr_q;
                bus.rf_write_val  = wb_data_q;
                state_next        = IDLE;
            end
            RD1: begin
                bus.rf_read_addr = rs1_q;
                state_next       = RD2;
            end
            RD2: begin
                bus.rf_read_addr = rs2_q;
                state_next       = CAP;
            end
            CAP:  state_next = RESP;
            RESP: begin
                bus.op_valid = 1'b1;
                if (bus.op_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
        end else begin
            if (state == IDLE) begin
                if (bus.wb_valid) begin
                    wb_addr_q <= bus.wb_addr;
                    wb_data_q <= bus.wb_data;
                end else if (bus.fetch_valid) begin
                    rs1_q <= bus.fetch_rs1;
                    rs2_q <= bus.fetch_rs2;
                end
            end
            // Register-file data lags the address by one cycle: rs1 lands in RD2, rs2 in CAP.
            if (state == RD2) op_a_q <= (ZERO_HARDWIRE && rs1_q == '0) ? '0 : bus.rf_read_value;
            if (state == CAP) op_b_q <= (ZERO_HARDWIRE && rs2_q == '0) ? '0 : bus.rf_read_value;
        end
    end

    assign bus.op_a = op_a_q;
    assign bus.op_b = op_b_q;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Randomised bench for regfile_access_sequencer: a behavioural register file answers the DUT,
// while an architectural register array predicts every operand the sequencer must return.
module tb_regfile_access_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   wr_cycles = 0;
    logic preload;

    logic [31:0] init_vals [32];
    logic [31:0] rf_mem    [32];
    logic [31:0] ref_regs  [32];

    regfile_access_sequencer_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_access_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.rf_r_or_w === 1'b0) wr_cycles <= wr_cycles + 1;

    // Single-port register file with a registered read port.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_vals[i];
        end else if (bus.rf_r_or_w === 1'b0) begin
            rf_mem[bus.rf_write_addr] <= bus.rf_write_val;
        end
        bus.rf_read_value <= rf_mem[bus.rf_read_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        @(negedge clk); #1;
        checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("FAIL reset_op_valid got=%0h exp=0", bus.op_valid); end
        checks++; if (bus.op_a !== 32'h0) begin failures++; $display("FAIL reset_op_a got=%0h exp=0", bus.op_a); end
        checks++; if (bus.op_b !== 32'h0) begin failures++; $display("FAIL reset_op_b got=%0h exp=0", bus.op_b); end
        checks++; if (bus.rf_r_or_w !== 1'b1) begin failures++; $display("FAIL reset_rf_r_or_w got=%0h exp=1", bus.rf_r_or_w); end
        checks++; if (bus.rf_read_addr !== 5'd0) begin failures++; $display("FAIL reset_rf_read_addr got=%0h exp=0", bus.rf_read_addr); end
        checks++; if (bus.rf_write_addr !== 5'd0) begin failures++; $display("FAIL reset_rf_write_addr got=%0h exp=0", bus.rf_write_addr); end
        checks++; if (bus.rf_write_val !== 32'h0) begin failures++; $display("FAIL reset_rf_write_val got=%0h exp=0", bus.rf_write_val); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", bus.busy); end
        checks++; if (bus.fetch_ready !== 1'b1) begin failures++; $display("FAIL reset_fetch_ready got=%0h exp=1", bus.fetch_ready); end
        checks++; if (bus.wb_ready !== 1'b1) begin failures++; $display("FAIL reset_wb_ready got=%0h exp=1", bus.wb_ready); end
    endtask

    task automatic test_write_run(input logic [4:0] addr, input logic [31:0] data);
        int wc0;
        bit drop;
        drop = (addr == 5'd0);
        @(negedge clk);
        bus.wb_valid = 1'b1; bus.wb_addr = addr; bus.wb_data = data; #1;
        checks++; if (bus.wb_ready !== 1'b1) begin failures++; $display("FAIL wr_wb_ready got=%0h exp=1", bus.wb_ready); end
        checks++; if (bus.fetch_ready !== 1'b0) begin failures++; $display("FAIL wr_fetch_blocked got=%0h exp=0", bus.fetch_ready); end
        wc0 = wr_cycles;
        @(negedge clk);
        bus.wb_valid = 1'b0; bus.wb_addr = 5'($urandom); bus.wb_data = $urandom; #1;
        if (drop) begin
            checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wr_x0_busy got=%0h exp=0", bus.busy); end
            checks++; if (bus.rf_r_or_w !== 1'b1) begin failures++; $display("FAIL wr_x0_r_or_w got=%0h exp=1", bus.rf_r_or_w); end
        end else begin
            checks++; if (bus.rf_r_or_w !== 1'b0) begin failures++; $display("FAIL wr_r_or_w got=%0h exp=0", bus.rf_r_or_w); end
            checks++; if (bus.rf_write_addr !== addr) begin failures++; $display("FAIL wr_addr got=%0h exp=%0h", bus.rf_write_addr, addr); end
            checks++; if (bus.rf_write_val !== data) begin failures++; $display("FAIL wr_val got=%0h exp=%0h", bus.rf_write_val, data); end
            checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%0h exp=1", bus.busy); end
            ref_regs[addr] = data;
        end
        @(negedge clk); #1;
        checks++; if (bus.rf_r_or_w !== 1'b1) begin failures++; $display("FAIL wr_after_r_or_w got=%0h exp=1", bus.rf_r_or_w); end
        checks++; if (bus.rf_write_addr !== 5'd0 || bus.rf_write_val !== 32'h0) begin
            failures++; $display("FAIL wr_after_idle_drive got=%0h/%0h exp=0/0", bus.rf_write_addr, bus.rf_write_val); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wr_after_busy got=%0h exp=0", bus.busy); end
        checks++; if (wr_cycles - wc0 !== (drop ? 0 : 1)) begin
            failures++; $display("FAIL wr_cycle_count got=%0d exp=%0d", wr_cycles - wc0, drop ? 0 : 1); end
    endtask

    task automatic test_fetch_run(input logic [4:0] rs1, input logic [4:0] rs2, input int hold, output int vcyc);
        logic [31:0] ea, eb;
        int lat, bad;
        ea = ref_regs[rs1];
        eb = ref_regs[rs2];
        @(negedge clk);
        bus.op_ready = (hold == 0);
        bus.fetch_valid = 1'b1; bus.fetch_rs1 = rs1; bus.fetch_rs2 = rs2; #1;
        checks++; if (bus.fetch_ready !== 1'b1) begin failures++; $display("FAIL fetch_ready got=%0h exp=1", bus.fetch_ready); end
        @(negedge clk);
        bus.fetch_valid = 1'b0; bus.fetch_rs1 = 5'($urandom); bus.fetch_rs2 = 5'($urandom); #1;
        checks++; if (bus.rf_read_addr !== rs1) begin failures++; $display("FAIL fetch_rd1_addr got=%0h exp=%0h", bus.rf_read_addr, rs1); end
        checks++; if (bus.busy !== 1'b1 || bus.op_valid !== 1'b0) begin
            failures++; $display("FAIL fetch_rd1_status got=%0h/%0h exp=1/0", bus.busy, bus.op_valid); end
        @(negedge clk); #1;
        checks++; if (bus.rf_read_addr !== rs2 || bus.rf_r_or_w !== 1'b1) begin
            failures++; $display("FAIL fetch_rd2_addr got=%0h/%0h exp=%0h/1", bus.rf_read_addr, bus.rf_r_or_w, rs2); end
        lat = 2;
        while (bus.op_valid !== 1'b1 && lat < 20) begin @(negedge clk); #1; lat++; end
        checks++; if (lat !== 4) begin failures++; $display("FAIL fetch_latency got=%0d exp=4", lat); end
        vcyc = cyc;
        checks++; if (bus.op_a !== ea) begin failures++; $display("FAIL fetch_op_a rs1=%0d got=%0h exp=%0h", rs1, bus.op_a, ea); end
        checks++; if (bus.op_b !== eb) begin failures++; $display("FAIL fetch_op_b rs2=%0d got=%0h exp=%0h", rs2, bus.op_b, eb); end
        if (hold > 0) begin
            bad = 0;
            bus.wb_valid = 1'b1; bus.wb_addr = 5'($urandom_range(1, 31)); bus.wb_data = $urandom;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk); #1;
                if (bus.op_valid !== 1'b1 || bus.op_a !== ea || bus.op_b !== eb ||
                    bus.fetch_ready !== 1'b0 || bus.wb_ready !== 1'b0) bad++;
            end
            checks++; if (bad !== 0) begin failures++; $display("FAIL resp_hold_stable got=%0d bad_cycles exp=0", bad); end
            bus.wb_valid = 1'b0;
            bus.op_ready = 1'b1;
            @(negedge clk); #1;
            checks++; if (bus.op_valid !== 1'b0 || bus.busy !== 1'b0) begin
                failures++; $display("FAIL resp_release got=%0h/%0h exp=0/0", bus.op_valid, bus.busy); end
        end
    endtask

    task automatic test_write_fetch();
        int vc;
        test_write_run(5'd5, 32'hDEADBEEF);
        test_fetch_run(5'd5, 5'd0, 0, vc);
    endtask

    task automatic test_simultaneous();
        int lat;
        @(negedge clk);
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h12345678;
        bus.fetch_valid = 1'b1; bus.fetch_rs1 = 5'd7; bus.fetch_rs2 = 5'd7; bus.op_ready = 1'b1; #1;
        checks++; if (bus.fetch_ready !== 1'b0 || bus.wb_ready !== 1'b1) begin
            failures++; $display("FAIL sim_ready got=%0h/%0h exp=0/1", bus.fetch_ready, bus.wb_ready); end
        @(negedge clk);
        bus.wb_valid = 1'b0; #1;
        checks++; if (bus.rf_r_or_w !== 1'b0 || bus.fetch_ready !== 1'b0) begin
            failures++; $display("FAIL sim_write_first got=%0h/%0h exp=0/0", bus.rf_r_or_w, bus.fetch_ready); end
        ref_regs[7] = 32'h12345678;
        @(negedge clk); #1;
        checks++; if (bus.fetch_ready !== 1'b1) begin failures++; $display("FAIL sim_fetch_ready got=%0h exp=1", bus.fetch_ready); end
        @(negedge clk);
        bus.fetch_valid = 1'b0; #1;
        checks++; if (bus.rf_read_addr !== 5'd7 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL sim_rd1 got=%0h/%0h exp=7/1", bus.rf_read_addr, bus.busy); end
        lat = 1;
        while (bus.op_valid !== 1'b1 && lat < 20) begin @(negedge clk); #1; lat++; end
        checks++; if (lat !== 4) begin failures++; $display("FAIL sim_latency got=%0d exp=4", lat); end
        checks++; if (bus.op_a !== ref_regs[7] || bus.op_b !== ref_regs[7]) begin
            failures++; $display("FAIL sim_operands got=%0h/%0h exp=12345678/12345678", bus.op_a, bus.op_b); end
    endtask

    task automatic test_x0_write();
        int vc;
        test_write_run(5'd0, 32'hFFFFFFFF);
        test_fetch_run(5'd0, 5'd0, 0, vc);
    endtask

    task automatic test_hold();
        int vc;
        test_fetch_run(5'd5, 5'd7, 10, vc);
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        for (int i = 1; i <= 4; i++) test_write_run(5'(i), 32'(i * 'h11));
        test_fetch_run(5'd1, 5'd2, 0, c1);
        test_fetch_run(5'd3, 5'd4, 0, c2);
        checks++; if (c2 - c1 !== 5) begin failures++; $display("FAIL b2b_spacing got=%0d exp=5", c2 - c1); end
    endtask

    task automatic test_reset_rd2();
        int spurious;
        @(negedge clk);
        bus.fetch_valid = 1'b1; bus.fetch_rs1 = 5'd1; bus.fetch_rs2 = 5'd2; bus.op_ready = 1'b1;
        @(negedge clk);
        bus.fetch_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (bus.rf_read_addr !== 5'd2) begin failures++; $display("FAIL rst_rd2_reached got=%0h exp=2", bus.rf_read_addr); end
        reset = 1'b1; #1;
        checks++; if (bus.op_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rf_r_or_w !== 1'b1) begin
            failures++; $display("FAIL rst_rd2_immediate got=%0h/%0h/%0h exp=0/0/1", bus.op_valid, bus.busy, bus.rf_r_or_w); end
        checks++; if (bus.op_a !== 32'h0 || bus.rf_read_addr !== 5'd0) begin
            failures++; $display("FAIL rst_rd2_cleared got=%0h/%0h exp=0/0", bus.op_a, bus.rf_read_addr); end
        @(negedge clk);
        reset = 1'b0; #1;
        checks++; if (bus.fetch_ready !== 1'b1) begin failures++; $display("FAIL rst_rd2_fetch_ready got=%0h exp=1", bus.fetch_ready); end
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (bus.op_valid !== 1'b0 || bus.busy !== 1'b0) spurious++;
        end
        checks++; if (spurious !== 0) begin failures++; $display("FAIL rst_rd2_spurious got=%0d exp=0", spurious); end
    endtask

    task automatic test_random();
        int vc;
        logic [4:0] a, b;
        for (int k = 0; k < 40; k++) begin
            a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            b = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if ($urandom_range(0, 2) == 0) test_write_run(a, $urandom);
            else test_fetch_run(a, b, ($urandom_range(0, 3) == 3) ? int'($urandom_range(1, 4)) : 0, vc);
        end
    endtask

    initial begin
        reset = 1'b1;
        preload = 1'b1;
        bus.fetch_valid = 1'b0; bus.fetch_rs1 = '0; bus.fetch_rs2 = '0;
        bus.op_ready = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        // x0 in the backing store holds garbage so forcing to zero is observable.
        for (int i = 0; i < 32; i++) begin
            init_vals[i] = $urandom | 32'h1;
            ref_regs[i]  = (i == 0) ? 32'h0 : init_vals[i];
        end
        repeat (2) @(negedge clk);
        preload = 1'b0;
        test_reset();
        reset = 1'b0;
        test_write_fetch();
        test_simultaneous();
        test_x0_write();
        test_hold();
        test_back_to_back();
        test_reset_rd2();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
